// File: rtl/l1_mem_pkg.sv
// Shared types and constants for the L1 line-transfer master.
// Holds the controller state encoding, the memory response codes and the default line width.
package l1_mem_pkg;

  localparam int LINE_WIDTH_DEFAULT = 128;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WB_REQ  = 3'd1,
    WB_WAIT = 3'd2,
    RD_REQ  = 3'd3,
    RD_WAIT = 3'd4,
    DONE    = 3'd5
  } state_t;

  function automatic logic resp_is_error(input logic [1:0] resp);
    return resp != RESP_OKAY;
  endfunction

endpackage

// File: rtl/l1_mem_master_if.sv
// Split read/write memory channel between the L1 master and the memory system.
// Request channels use valid/ready; reply channels are valid-only pulses with no backpressure.
interface Mem_ift
  import l1_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = LINE_WIDTH_DEFAULT
) ();

  logic                  r_request_valid;
  logic                  r_request_ready;
  logic [ADDR_WIDTH-1:0] raddr;

  logic                  w_request_valid;
  logic                  w_request_ready;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [LINE_WIDTH-1:0] wdata;

  logic                  r_reply_valid;
  logic [LINE_WIDTH-1:0] rdata;
  logic [1:0]            rresp;

  logic                  w_reply_valid;
  logic [1:0]            bresp;

  modport Master (
    output r_request_valid, raddr,
    input  r_request_ready,
    output w_request_valid, waddr, wdata,
    input  w_request_ready,
    input  r_reply_valid, rdata, rresp,
    input  w_reply_valid, bresp
  );

  modport Slave (
    input  r_request_valid, raddr,
    output r_request_ready,
    input  w_request_valid, waddr, wdata,
    output w_request_ready,
    output r_reply_valid, rdata, rresp,
    output w_reply_valid, bresp
  );

endinterface

// File: rtl/l1_mem_timeout.sv
// Reply-wait watchdog: counts cycles while enabled and flags expiry on the last allowed cycle.
// Clear has priority; the count saturates once expired so it never wraps.
module l1_mem_timeout #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] count_reg;

  // Expires during the TIMEOUT_CYCLES-th waiting cycle, so the owner leaves after exactly that many.
  assign expired = enable && (count_reg == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable && !expired) begin
      count_reg <= count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/l1_mem_master.sv
// L1 miss engine: optional dirty-victim writeback followed by a line refill over Mem_ift,
// with a bounded wait per reply and a sticky error reported alongside the refill pulse.
module l1_mem_master
  import l1_mem_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int LINE_WIDTH     = LINE_WIDTH_DEFAULT,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wb,
  input  logic [ADDR_WIDTH-1:0] req_wb_addr,
  input  logic [LINE_WIDTH-1:0] req_wb_data,
  input  logic [ADDR_WIDTH-1:0] req_rd_addr,
  output logic                  refill_valid,
  output logic [LINE_WIDTH-1:0] refill_data,
  output logic                  err,
  Mem_ift.Master                mem_ift
);

  localparam int LINE_BYTES = LINE_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'(LINE_BYTES - 1);

  state_t                state_reg, state_next;
  logic                  wb_reg, wb_next;
  logic [ADDR_WIDTH-1:0] wb_addr_reg, wb_addr_next;
  logic [LINE_WIDTH-1:0] wb_data_reg, wb_data_next;
  logic [ADDR_WIDTH-1:0] rd_addr_reg, rd_addr_next;
  logic [LINE_WIDTH-1:0] refill_data_reg, refill_data_next;
  logic                  err_flag_reg, err_flag_next;

  logic in_wait;
  logic timeout_expired;

  assign in_wait = (state_reg == WB_WAIT) || (state_reg == RD_WAIT);

  // Count restarts every time a wait state is entered because it is held clear outside them.
  l1_mem_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (!in_wait),
    .enable (in_wait),
    .expired(timeout_expired)
  );

  assign refill_data = refill_data_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      wb_reg          <= 1'b0;
      wb_addr_reg     <= '0;
      wb_data_reg     <= '0;
      rd_addr_reg     <= '0;
      refill_data_reg <= '0;
      err_flag_reg    <= 1'b0;
    end else begin
      state_reg       <= state_next;
      wb_reg          <= wb_next;
      wb_addr_reg     <= wb_addr_next;
      wb_data_reg     <= wb_data_next;
      rd_addr_reg     <= rd_addr_next;
      refill_data_reg <= refill_data_next;
      err_flag_reg    <= err_flag_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    wb_next          = wb_reg;
    wb_addr_next     = wb_addr_reg;
    wb_data_next     = wb_data_reg;
    rd_addr_next     = rd_addr_reg;
    refill_data_next = refill_data_reg;
    err_flag_next    = err_flag_reg;

    req_ready        = 1'b0;
    refill_valid     = 1'b0;
    err              = 1'b0;

    // Address/data are driven from latched state every cycle so they stay stable under backpressure.
    mem_ift.r_request_valid = 1'b0;
    mem_ift.raddr           = rd_addr_reg & LINE_MASK;
    mem_ift.w_request_valid = 1'b0;
    mem_ift.waddr           = wb_addr_reg & LINE_MASK;
    mem_ift.wdata           = wb_data_reg;

    case (state_reg)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          wb_next      = req_wb;
          wb_addr_next = req_wb_addr;
          wb_data_next = req_wb_data;
          rd_addr_next = req_rd_addr;
          state_next   = req_wb ? WB_REQ : RD_REQ;
        end
      end

      WB_REQ: begin
        mem_ift.w_request_valid = 1'b1;
        if (mem_ift.w_request_ready) begin
          state_next = WB_WAIT;
        end
      end

      WB_WAIT: begin
        if (mem_ift.w_reply_valid) begin
          if (resp_is_error(mem_ift.bresp)) begin
            err_flag_next = 1'b1;
          end
          state_next = RD_REQ;
        end else if (timeout_expired) begin
          // A lost writeback abandons the refill; the cache retries the whole miss.
          err_flag_next = 1'b1;
          state_next    = DONE;
        end
      end

      RD_REQ: begin
        mem_ift.r_request_valid = 1'b1;
        if (mem_ift.r_request_ready) begin
          state_next = RD_WAIT;
        end
      end

      RD_WAIT: begin
        if (mem_ift.r_reply_valid) begin
          refill_data_next = mem_ift.rdata;
          if (resp_is_error(mem_ift.rresp)) begin
            err_flag_next = 1'b1;
          end
          state_next = DONE;
        end else if (timeout_expired) begin
          err_flag_next = 1'b1;
          state_next    = DONE;
        end
      end

      DONE: begin
        refill_valid  = 1'b1;
        err           = err_flag_reg;
        err_flag_next = 1'b0;
        state_next    = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Memory-side handshake invariants: one request channel at a time, requests held until accepted.
  a_one_valid: assert property (@(posedge clk) disable iff (rst)
    !(mem_ift.r_request_valid && mem_ift.w_request_valid));

  a_rd_hold: assert property (@(posedge clk) disable iff (rst)
    (mem_ift.r_request_valid && !mem_ift.r_request_ready)
      |=> (mem_ift.r_request_valid && $stable(mem_ift.raddr)));

  a_wr_hold: assert property (@(posedge clk) disable iff (rst)
    (mem_ift.w_request_valid && !mem_ift.w_request_ready)
      |=> (mem_ift.w_request_valid && $stable(mem_ift.waddr) && $stable(mem_ift.wdata)));

endmodule

// File: doc/l1_mem_master.md
L1_MEM_MASTER -- requirements
Module: l1_mem_master

Interface
REQ-001 Parameters: ADDR_WIDTH, default 32, byte-address width.
REQ-002 Parameters: LINE_WIDTH, default 128, cache-line width in bits; LINE_BYTES = LINE_WIDTH/8.
REQ-003 Parameters: TIMEOUT_CYCLES, default 64, maximum wait for a memory reply.
REQ-004 Ports: clk  in  1  single clock; all state on rising edge.
REQ-005 Ports: rst  in  1  reset, asynchronous and active-high.
REQ-006 Ports: req_valid  in  1  cache requests a line transaction.
REQ-007 Ports: req_ready  out  1  block accepts a request (high only in IDLE).
REQ-008 Ports: req_wb  in  1  a dirty victim is written back before the refill.
REQ-009 Ports: req_wb_addr  in  ADDR_WIDTH  victim byte address.
REQ-010 Ports: req_wb_data  in  LINE_WIDTH  victim line.
REQ-011 Ports: req_rd_addr  in  ADDR_WIDTH  refill byte address.
REQ-012 Ports: refill_valid  out  1  one-cycle pulse when refill_data is valid.
REQ-013 Ports: refill_data  out  LINE_WIDTH  returned line.
REQ-014 Ports: err  out  1  one-cycle pulse with refill_valid when the transaction failed.
REQ-015 Ports: mem_ift  Mem_ift.Master  --  memory side: r/w request valid/ready/bits, r/w reply valid/bits (rdata, rresp, bresp).

Function
REQ-016 FSM states: IDLE, WB_REQ, WB_WAIT, RD_REQ, RD_WAIT, DONE.
REQ-017 IDLE: req_ready=1; on req_valid, latch all req_* fields; next WB_REQ if req_wb else RD_REQ.
REQ-018 WB_REQ: w_request_valid=1, waddr = latched wb addr with low log2(LINE_BYTES) bits zeroed, wdata = latched line; hold stable until w_request_ready; then WB_WAIT.
REQ-019 WB_WAIT: on w_reply_valid go RD_REQ; bresp != 2'b00 sets sticky error flag.
REQ-020 RD_REQ: r_request_valid=1, raddr = latched rd addr, low bits zeroed; hold until r_request_ready; then RD_WAIT.
REQ-021 RD_WAIT: on r_reply_valid capture rdata into refill_data register, rresp != 2'b00 sets error flag; next DONE.
REQ-022 DONE: refill_valid=1 for exactly one cycle, err = error flag; clear flag; next IDLE.
REQ-023 Reply channels have no ready; block SHALL accept any reply pulse in WAIT states; replies in other states SHALL be ignored.
REQ-024 Request valids SHALL never drop before ready within a handshake; at most one outstanding request.
REQ-025 Both request valids SHALL never be high in the same cycle.
REQ-026 Timeout counter resets on WAIT-state entry, increments each WAIT cycle; at TIMEOUT_CYCLES without reply, set error flag and go DONE (skip read if in WB_WAIT).
REQ-027 Minimum latency with zero-wait memory (ready=1, reply one cycle later): read-only 4 cycles from accept to refill_valid; with writeback 6.
REQ-028 refill_data SHALL hold its value until the next RD_WAIT capture; on timeout it SHALL hold its previous value.
REQ-029 imem channels are not driven by this block.

Reset
REQ-030 On rst: state IDLE, all request valids 0, refill_valid 0, err 0, refill_data 0, error flag 0, timeout counter 0.
REQ-031 rst asserted mid-transaction SHALL abort immediately; no refill_valid follows deassertion; late replies after reset SHALL be ignored.

Structure
REQ-032 l1_mem_pkg SHALL hold the state enum type, OKAY response constant 2'b00, and LINE_WIDTH default.
REQ-033 One sub-module, l1_mem_timeout: counter with clear, enable, and expired output.
REQ-034 Single always_ff for state/registers, one always_comb for next state and outputs.

Verification
REQ-035 Read only: req_rd_addr=0x0000_0123, zero-wait slave -> raddr=0x0000_0120, refill_valid 4 cycles later, refill_data=slave line, err=0.
REQ-036 Writeback+read: req_wb_addr=0x40, data=0xDEADBEEF_..._01 -> write at 0x40 with exact data, then read issued only after w_reply_valid, refill_valid at cycle 6.
REQ-037 Backpressure: r_request_ready low 5 cycles -> raddr/valid stable for all 5, exactly one handshake.
REQ-038 Error: rresp=2'b10 -> refill_valid and err pulse together for one cycle; next request has err=0.
REQ-039 Timeout: no r_reply_valid for 64 cycles -> err=1 with refill_valid, return to IDLE, req_ready=1.
REQ-040 Reset in WB_WAIT, then late w_reply_valid -> outputs at reset values, no refill_valid, no read issued.
